exc_ctrl: RTL and testbench

Exception sequencer for the multicycle MIPS CPU. It takes the ALU overflow error flag, the decoder's illegal-opcode flag, a level interrupt request and decoded `eret`. It then kills the faulting instruction's writeback, records EPC and Cause, and sequences the main controller through a redirect to the exception vector or back to EPC. It sits beside the main multicycle control FSM; the PC mux and the register-file write enable are gated by its outputs.

---
 rtl/mips_exc_pkg.sv | 26 ++
 rtl/exc_prio_enc.sv | 37 +++
 rtl/exc_ctrl.sv | 108 ++++++++++
 tb/tb_exc_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_exc_pkg.sv
// Shared constants and encodings for the MIPS exception sequencer.
package mips_exc_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned EXCCODE_W = 5;

    localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

    localparam logic [EXCCODE_W-1:0] EXCCODE_INT = 5'd0;
    localparam logic [EXCCODE_W-1:0] EXCCODE_RI  = 5'd10;
    localparam logic [EXCCODE_W-1:0] EXCCODE_OV  = 5'd12;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SAVE  = 2'd1,
        REDIR = 2'd2,
        RET   = 2'd3
    } exc_state_t;

    // Which address is recorded as EPC: faulting instruction or the one after it.
    typedef enum logic {
        EPC_CUR  = 1'b0,
        EPC_NEXT = 1'b1
    } epc_sel_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Prioritises exception triggers (RI > Ov > Int > eret) and selects ExcCode / EPC source.
module exc_prio_enc
    import mips_exc_pkg::*;
(
    input  logic                 trig_ri,
    input  logic                 trig_ov,
    input  logic                 trig_int,
    input  logic                 trig_eret,
    input  logic                 exl,
    output logic                 take,
    output logic                 is_eret,
    output logic [EXCCODE_W-1:0] exc_code,
    output epc_sel_t             epc_sel
);

    always_comb begin
        take     = 1'b0;
        is_eret  = 1'b0;
        exc_code = EXCCODE_INT;
        epc_sel  = EPC_CUR;
        if (trig_ri) begin
            take     = 1'b1;
            exc_code = EXCCODE_RI;
        end else if (trig_ov) begin
            take     = 1'b1;
            exc_code = EXCCODE_OV;
        end else if (trig_int && !exl) begin
            // Interrupts return to the next instruction; masked while in the handler.
            take     = 1'b1;
            exc_code = EXCCODE_INT;
            epc_sel  = EPC_NEXT;
        end else if (trig_eret) begin
            is_eret = 1'b1;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: kills the faulting writeback, records EPC/Cause and
// steers the main controller to the exception vector or back to EPC.
module exc_ctrl
    import mips_exc_pkg::*;
#(
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stage_id,
    input  logic            stage_ex,
    input  logic            ovf_err,
    input  logic            illegal_op,
    input  logic            eret,
    input  logic            irq,
    input  logic            instr_done,
    input  logic [XLEN-1:0] cur_pc,
    output logic            wb_kill,
    output logic            ctrl_stall,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] cause,
    output logic            exl
);

    exc_state_t           state, state_nxt;
    logic                 take, is_eret;
    logic [EXCCODE_W-1:0] exc_code;
    epc_sel_t             epc_sel;
    logic                 in_run;

    assign in_run = (state == RUN);

    exc_prio_enc u_prio (
        .trig_ri   (stage_id & illegal_op),
        .trig_ov   (stage_ex & ovf_err),
        .trig_int  (instr_done & irq),
        .trig_eret (stage_id & eret),
        .exl       (exl),
        .take      (take),
        .is_eret   (is_eret),
        .exc_code  (exc_code),
        .epc_sel   (epc_sel)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Next-state logic; triggers are only looked at in RUN
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (take)         state_nxt = SAVE;
                else if (is_eret) state_nxt = RET;
            end
            SAVE:    state_nxt = REDIR;
            REDIR:   state_nxt = RUN;
            RET:     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Strobes to the main controller and PC mux
    always_comb begin
        wb_kill     = 1'b0;
        ctrl_stall  = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = EXC_VECTOR;
        case (state)
            RUN:   wb_kill = take | is_eret;
            SAVE: begin
                wb_kill    = 1'b1;
                ctrl_stall = 1'b1;
            end
            REDIR: begin
                pc_redirect = 1'b1;
                ctrl_stall  = 1'b1;
            end
            RET: begin
                pc_redirect = 1'b1;
                ctrl_stall  = 1'b1;
                pc_target   = epc;
            end
            default: ;
        endcase
    end

    // EPC is frozen on nested exceptions so the outermost return address survives
    always_ff @(posedge clk) begin
        if (reset) begin
            epc   <= '0;
            cause <= '0;
            exl   <= 1'b0;
        end else if (in_run && take) begin
            cause <= XLEN'({exc_code, 2'b00});
            exl   <= 1'b1;
            if (!exl) epc <= (epc_sel == EPC_NEXT) ? cur_pc + XLEN'(4) : cur_pc;
        end else if (state == RET) begin
            exl <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus random traffic
// against a schedule-of-actions reference model.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset, stage_id, stage_ex, ovf_err, illegal_op, eret, irq, instr_done;
    logic [31:0] cur_pc;
    logic        wb_kill, ctrl_stall, pc_redirect, exl;
    logic [31:0] pc_target, epc, cause;

    exc_ctrl #(.EXC_VECTOR(VEC)) dut (
        .clk         (clk),
        .reset       (reset),
        .stage_id    (stage_id),
        .stage_ex    (stage_ex),
        .ovf_err     (ovf_err),
        .illegal_op  (illegal_op),
        .eret        (eret),
        .irq         (irq),
        .instr_done  (instr_done),
        .cur_pc      (cur_pc),
        .wb_kill     (wb_kill),
        .ctrl_stall  (ctrl_stall),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .epc         (epc),
        .cause       (cause),
        .exl         (exl)
    );

    always #5 clk = ~clk;

    // One entry per upcoming non-RUN cycle: what the sequencer must show then.
    typedef struct {
        bit kill;
        bit stall;
        bit redir;
        bit use_epc;
        bit clr_exl;
    } act_t;

    act_t        sched[$];
    logic [31:0] m_epc   = '0;
    logic [31:0] m_cause = '0;
    bit          m_exl   = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, compare against the model, then advance the model at the edge.
    task automatic step(input bit rst, input bit sid, input bit sex, input bit ovf,
                        input bit ill, input bit er, input bit iq, input bit done,
                        input logic [31:0] pc);
        bit          ri, ov, it, taken, ert, e_kill, e_stall, e_redir;
        logic [31:0] e_tgt;
        int          code;
        @(negedge clk);
        reset = rst; stage_id = sid; stage_ex = sex; ovf_err = ovf;
        illegal_op = ill; eret = er; irq = iq; instr_done = done; cur_pc = pc;
        #1;
        ri    = sid & ill;
        ov    = sex & ovf;
        it    = done & iq & !m_exl;
        taken = ri | ov | it;
        ert   = sid & er & !taken;
        code  = ri ? 10 : (ov ? 12 : 0);
        if (sched.size() != 0) begin
            e_kill  = sched[0].kill;
            e_stall = sched[0].stall;
            e_redir = sched[0].redir;
            e_tgt   = sched[0].use_epc ? m_epc : VEC;
        end else begin
            e_kill  = taken | ert;
            e_stall = 1'b0;
            e_redir = 1'b0;
            e_tgt   = VEC;
        end
        check("wb_kill",     32'(wb_kill),     32'(e_kill));
        check("ctrl_stall",  32'(ctrl_stall),  32'(e_stall));
        check("pc_redirect", 32'(pc_redirect), 32'(e_redir));
        check("pc_target",   pc_target,        e_tgt);
        check("epc",         epc,              m_epc);
        check("cause",       cause,            m_cause);
        check("exl",         32'(exl),         32'(m_exl));
        @(posedge clk);
        if (rst) begin
            sched.delete();
            m_epc = '0; m_cause = '0; m_exl = 1'b0;
        end else if (sched.size() != 0) begin
            if (sched[0].clr_exl) m_exl = 1'b0;
            void'(sched.pop_front());
        end else if (taken) begin
            m_cause = 32'(code * 4);
            if (!m_exl) m_epc = (ri | ov) ? pc : pc + 32'd4;
            m_exl = 1'b1;
            sched.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
            sched.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        end else if (ert) begin
            sched.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000);
    endtask

    initial begin
        reset = 1'b1; stage_id = 0; stage_ex = 0; ovf_err = 0; illegal_op = 0;
        eret = 0; irq = 0; instr_done = 0; cur_pc = '0;
        @(posedge clk);
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        check("rst_epc", epc, 32'h0);
        check("rst_cause", cause, 32'h0);
        check("rst_exl", 32'(exl), 32'h0);
        check("rst_redirect", 32'(pc_redirect), 32'h0);

        // Overflow in EX
        step(0, 0, 1, 1, 0, 0, 0, 0, 32'h0040_0010);
        #1;
        check("ov_epc", epc, 32'h0040_0010);
        check("ov_cause", cause, 32'h30);
        check("ov_exl", 32'(exl), 32'h1);
        idle(); #1;
        check("ov_redirect", 32'(pc_redirect), 32'h1);
        check("ov_target", pc_target, 32'h8000_0180);
        idle();
        step(0, 1, 0, 0, 0, 1, 0, 0, 32'h8000_0180);
        idle();

        // Interrupt, then masking while in the handler
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0020);
        #1;
        check("int_epc", epc, 32'h0040_0024);
        check("int_cause", cause, 32'h0);
        idle(); idle();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 1, 32'h8000_0180 + 32'(4 * i));
            #1;
            check("int_masked", 32'(pc_redirect | ctrl_stall), 32'h0);
        end

        // Nested RI inside the handler
        step(0, 1, 0, 0, 1, 0, 0, 0, 32'h8000_0190);
        #1;
        check("nest_cause", cause, 32'h28);
        check("nest_epc", epc, 32'h0040_0024);
        idle(); #1;
        check("nest_target", pc_target, 32'h8000_0180);
        idle();

        // eret back to EPC
        step(0, 1, 0, 0, 0, 1, 0, 0, 32'h8000_01a0);
        #1;
        check("eret_redirect", 32'(pc_redirect), 32'h1);
        check("eret_target", pc_target, 32'h0040_0024);
        idle(); #1;
        check("eret_exl", 32'(exl), 32'h0);

        // Reset while in SAVE
        step(0, 0, 1, 1, 0, 0, 0, 0, 32'h1234_5678);
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        check("mid_epc", epc, 32'h0);
        check("mid_cause", cause, 32'h0);
        check("mid_exl", 32'(exl), 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("mid_no_redirect", 32'(pc_redirect), 32'h0);
            idle();
        end

        // Priority: RI beats Ov and Int
        step(0, 1, 1, 1, 1, 0, 1, 1, 32'h0040_0040);
        #1;
        check("prio_cause", cause, 32'h28);
        idle(); idle();
        step(0, 1, 0, 0, 0, 1, 0, 0, 32'h8000_0180);
        idle();

        // EPC wrap on interrupt at the top of the address space
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        #1;
        check("wrap_epc", epc, 32'h0000_0000);
        idle(); idle();
        step(0, 1, 0, 0, 0, 1, 0, 0, 32'h8000_0180);
        idle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          rst, sid, sex, ovf, ill, er, iq, done;
            logic [31:0] pc;
            rst  = ($urandom % 60) == 0;
            sid  = !rst && ($urandom % 2 == 0);
            sex  = !rst && !sid && ($urandom % 2 == 0);
            ovf  = !rst && ($urandom % 5 == 0);
            ill  = !rst && ($urandom % 8 == 0);
            er   = !rst && ($urandom % 6 == 0);
            iq   = !rst && ($urandom % 4 == 0);
            done = !rst && ($urandom % 3 == 0);
            pc   = ($urandom % 16 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            step(rst, sid, sex, ovf, ill, er, iq, done, pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
